// File: rtl/adder_arbiter_if.sv
// Request/result bus between up to four adder requesters and the shared
// adder_arbiter; the master side drives requests and consumes results.
interface adder_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic [3:0]         gnt;
    logic               res_valid;
    logic [1:0]         res_id;
    logic [WIDTH-1:0]   res_sum;
    logic               res_carry;
    logic               res_ready;
    logic               busy;
    logic [7:0]         op_count;

    modport master (
        output req, req_a, req_b, res_ready,
        input  gnt, res_valid, res_id, res_sum, res_carry, busy, op_count
    );

    modport slave (
        input  req, req_a, req_b, res_ready,
        output gnt, res_valid, res_id, res_sum, res_carry, busy, op_count
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a single WIDTH-bit adder: IDLE captures the
// winner's operands, CALC registers the sum, HOLD presents it until consumed.
module adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_last_grant;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_valid;
    logic [1:0]       r_id;
    logic [7:0]       r_op_count;

    logic [1:0]       w_win_idx;
    logic [1:0]       w_cand;
    logic             w_win_found;
    logic [WIDTH:0]   w_full_sum;

    // Search begins one past the last grant and wraps through all four slots.
    always_comb begin
        w_win_idx   = r_last_grant;
        w_win_found = 1'b0;
        w_cand      = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_cand = r_last_grant + 2'(k);
            if (!w_win_found && bus.req[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_win_found) w_next = CALC;
            CALC:    w_next = HOLD;
            HOLD:    if (bus.res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    assign w_full_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 2'd3;
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_valid      <= 1'b0;
            r_id         <= '0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_idx        <= w_win_idx;
                        r_last_grant <= w_win_idx;
                        r_a          <= bus.req_a[w_win_idx*WIDTH +: WIDTH];
                        r_b          <= bus.req_b[w_win_idx*WIDTH +: WIDTH];
                    end
                end
                CALC: begin
                    r_sum   <= w_full_sum[WIDTH-1:0];
                    r_carry <= w_full_sum[WIDTH];
                    r_id    <= r_idx;
                    r_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        r_valid    <= 1'b0;
                        r_op_count <= r_op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.gnt = '0;
        if (r_state == CALC) bus.gnt = 4'b0001 << r_idx;
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.res_valid = r_valid;
    assign bus.res_id    = r_id;
    assign bus.res_sum   = r_sum;
    assign bus.res_carry = r_carry;
    assign bus.op_count  = r_op_count;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter at WIDTH=2: latency, hold stability,
// round-robin order, asynchronous reset and op_count wrap.
module tb_adder_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    adder_arbiter_if #(.WIDTH(W)) bus ();

    adder_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    // Returns the first nonzero gnt seen at a falling edge and how many
    // falling edges that took; g stays 0 if the bound runs out.
    task automatic wait_gnt(output logic [3:0] g, output int n);
        g = '0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.gnt !== 4'b0000) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        #12;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.op_count !== 8'd0) begin errors++; $display("FAIL reset_opcount: got %0d want 0", bus.op_count); end
        checks++; if ({bus.res_id, bus.res_sum, bus.res_carry} !== 5'b0) begin errors++; $display("FAIL reset_result: got %b want 00000", {bus.res_id, bus.res_sum, bus.res_carry}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.req = 4'b0001;
        set_op(0, 2'b01, 2'b01);
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b want 0001", bus.gnt); end
        checks++; if ({bus.busy, bus.res_valid} !== 2'b10) begin errors++; $display("FAIL basic_calc_flags: got %b want 10", {bus.busy, bus.res_valid}); end
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL basic_gnt_drop: got %b want 0000", bus.gnt); end
        checks++; if ({bus.res_valid, bus.res_id, bus.res_sum, bus.res_carry} !== 6'b1_00_10_0) begin errors++; $display("FAIL basic_result: got %b want 100100", {bus.res_valid, bus.res_id, bus.res_sum, bus.res_carry}); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL basic_consume_flags: got %b want 00", {bus.res_valid, bus.busy}); end
        checks++; if (bus.op_count !== 8'd1) begin errors++; $display("FAIL basic_opcount: got %0d want 1", bus.op_count); end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_hold();
        bus.req = 4'b0001;
        set_op(0, 2'b11, 2'b11);
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL hold_gnt: got %b want 0001", bus.gnt); end
        bus.req = '0;
        set_op(0, 2'b00, 2'b01);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.res_valid, bus.busy, bus.res_id, bus.res_sum, bus.res_carry} !== 7'b1_1_00_10_1) begin errors++; $display("FAIL hold_stable[%0d]: got %b want 1100101", i, {bus.res_valid, bus.busy, bus.res_id, bus.res_sum, bus.res_carry}); end
            checks++; if (bus.op_count !== 8'd1) begin errors++; $display("FAIL hold_opcount[%0d]: got %0d want 1", i, bus.op_count); end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.busy, bus.op_count} !== {2'b00, 8'd2}) begin errors++; $display("FAIL hold_release: got valid/busy/count %b/%b/%0d want 0/0/2", bus.res_valid, bus.busy, bus.op_count); end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        int         n;
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [1:0] esum;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_op(i, 2'(i), 2'b01);
        bus.req       = 4'b1111;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, n);
            checks++; if (g !== (4'b0001 << order[k])) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, g, 4'b0001 << order[k]); end
            checks++; if (n !== ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d edges want %0d", k, n, (k == 0) ? 1 : 2); end
            @(negedge clk);
            esum = 2'(order[k] + 1);
            checks++; if ({bus.res_valid, bus.res_id, bus.res_sum, bus.res_carry} !== {1'b1, 2'(order[k]), esum, order[k] == 3}) begin errors++; $display("FAIL rr_result[%0d]: got %b want %b", k, {bus.res_valid, bus.res_id, bus.res_sum, bus.res_carry}, {1'b1, 2'(order[k]), esum, order[k] == 3}); end
        end
    endtask

    task automatic test_masked_rotation();
        logic [3:0] g;
        int         n;
        int         order [3] = '{3, 0, 1};
        bus.req = 4'b0100;
        wait_gnt(g, n);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL mask_first: got %b want 0100", g); end
        bus.req = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g, n);
            checks++; if (g !== (4'b0001 << order[k])) begin errors++; $display("FAIL mask_gnt[%0d]: got %b want %b", k, g, 4'b0001 << order[k]); end
            @(negedge clk);
            checks++; if (bus.res_id !== 2'(order[k])) begin errors++; $display("FAIL mask_id[%0d]: got %0d want %0d", k, bus.res_id, order[k]); end
        end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({bus.busy, bus.op_count} !== {1'b0, 8'd9}) begin errors++; $display("FAIL mask_drain: got busy/count %b/%0d want 0/9", bus.busy, bus.op_count); end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] g;
        int         n;
        bus.res_ready = 1'b0;
        bus.req       = 4'b0001;
        wait_gnt(g, n);
        bus.req = '0;
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.busy} !== 2'b11) begin errors++; $display("FAIL mid_in_hold: got %b want 11", {bus.res_valid, bus.busy}); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({bus.res_valid, bus.busy, bus.gnt} !== 6'b0) begin errors++; $display("FAIL mid_async_flags: got %b want 000000", {bus.res_valid, bus.busy, bus.gnt}); end
        checks++; if ({bus.op_count, bus.res_sum, bus.res_carry} !== 11'b0) begin errors++; $display("FAIL mid_async_data: got count %0d sum %b carry %b want 0", bus.op_count, bus.res_sum, bus.res_carry); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.gnt, bus.res_valid, bus.busy} !== 6'b0) begin errors++; $display("FAIL mid_idle_after: got %b want 000000", {bus.gnt, bus.res_valid, bus.busy}); end
        bus.req = 4'b0100;
        set_op(2, 2'b10, 2'b01);
        wait_gnt(g, n);
        checks++; if (g !== 4'b0100 || n !== 1) begin errors++; $display("FAIL mid_regrant: got %b after %0d edges want 0100 after 1", g, n); end
        bus.req = 4'b0011;
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.res_id, bus.res_sum, bus.res_carry} !== 5'b10_11_0) begin errors++; $display("FAIL mid_result: got %b want 10110", {bus.res_id, bus.res_sum, bus.res_carry}); end
        wait_gnt(g, n);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL mid_wrap_gnt: got %b want 0001", g); end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        int         n;
        int         bad = 0;
        pulse_reset();
        bus.res_ready = 1'b1;
        set_op(0, 2'b01, 2'b00);
        for (int i = 1; i <= 256; i++) begin
            bus.req = 4'b0001;
            wait_gnt(g, n);
            if (g !== 4'b0001) bad++;
            bus.req = '0;
            @(negedge clk);
            @(negedge clk);
            if (i == 255) begin
                checks++; if (bus.op_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", bus.op_count); end
            end
        end
        checks++; if (bus.op_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", bus.op_count); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_grants: got %0d missing grants want 0", bad); end
        bus.res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_round_robin();
        test_masked_rotation();
        test_reset_mid_hold();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
